mdu_sched: RTL and testbench

- Sequencing controller for the multiply/divide unit (MDU) and its HI/LO register pair in the pipelined MIPS core.
- Sits in the E stage. Consumes the decoder's start, multctrl, muwe and mure controls, plus the D-stage ismu flag.
- Models the fixed multicycle latency of mult/div, owns HI/LO, and produces the pipeline stall for any MDU instruction issued while an operation is in flight.

---
 rtl/mdu_sched.sv | 97 +++++++++
 tb/tb_mdu_sched.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/mdu_sched.sv
// mdu_sched: E-stage multiply/divide sequencer that owns HI/LO and raises the MDU stall
module mdu_sched #(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10,
    parameter int CNT_W   = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [2:0]  i_multctrl,
    input  logic [1:0]  i_muwe,
    input  logic [1:0]  i_mure,
    input  logic [31:0] i_rs_data,
    input  logic [31:0] i_rt_data,
    input  logic        i_ismu_d,
    output logic        o_busy,
    output logic        o_stall,
    output logic [31:0] o_rdata,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_a, r_b, r_hi, r_lo;
    logic [2:0]       r_op;
    logic             w_valid, w_accept, w_done, w_wr, w_ovf;
    logic signed [63:0] w_sa64, w_sb64, w_smul;
    logic signed [31:0] w_sa, w_sb, w_sq, w_sr;
    logic [63:0]      w_umul, w_res;

    assign w_valid  = (i_multctrl != 3'd0) && (i_multctrl < 3'd5);
    assign w_accept = (r_state == IDLE) && i_start && w_valid;
    assign w_done   = (r_state == RUN) && (r_cnt == CNT_W'(1));

    // Result of the latched operation; INT_MIN/-1 is pinned so it never depends on simulator overflow behaviour
    always_comb begin
        w_sa   = r_a;
        w_sb   = r_b;
        w_sa64 = {{32{r_a[31]}}, r_a};
        w_sb64 = {{32{r_b[31]}}, r_b};
        w_smul = w_sa64 * w_sb64;
        w_umul = {32'd0, r_a} * {32'd0, r_b};
        w_ovf  = (r_a == 32'h8000_0000) && (r_b == 32'hFFFF_FFFF);
        w_sq   = (r_b == 32'd0) ? 32'sd0 : w_sa / w_sb;
        w_sr   = (r_b == 32'd0) ? 32'sd0 : w_sa % w_sb;
        w_res  = (r_op == 3'd1) ? w_smul :
                 (r_op == 3'd2) ? w_umul :
                 (r_op == 3'd3) ? (w_ovf ? {32'd0, 32'h8000_0000} : {w_sr, w_sq}) :
                 (r_b == 32'd0) ? 64'd0 : {r_a % r_b, r_a / r_b};
        w_wr   = (r_op <= 3'd2) || (r_b != 32'd0);
    end

    // Operation sequencing: latch on accept, count down the fixed latency, return to IDLE
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
        end else if (w_accept) begin
            r_state <= RUN;
            r_cnt   <= (i_multctrl <= 3'd2) ? CNT_W'(MUL_LAT) : CNT_W'(DIV_LAT);
            r_a     <= i_rs_data;
            r_b     <= i_rt_data;
            r_op    <= i_multctrl;
        end else if (w_done) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_cnt   <= r_cnt - CNT_W'(1);
        end
    end

    // HI/LO update: completion result wins; mthi/mtlo only when idle and no start is presented
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_done) begin
            if (w_wr) {r_hi, r_lo} <= w_res;
        end else if ((r_state == IDLE) && !i_start && (i_muwe == 2'd1)) begin
            r_hi <= i_rs_data;
        end else if ((r_state == IDLE) && !i_start && (i_muwe == 2'd2)) begin
            r_lo <= i_rs_data;
        end
    end

    assign o_busy  = (r_state == RUN);
    assign o_stall = i_ismu_d && (o_busy || (i_start && w_valid));
    assign o_rdata = (i_mure == 2'd1) ? r_hi : (i_mure == 2'd2) ? r_lo : 32'd0;
    assign o_hi    = r_hi;
    assign o_lo    = r_lo;
endmodule

// File: tb/tb_mdu_sched.sv
// tb_mdu_sched: vector table plus scoreboard for the MDU sequencer
module tb_mdu_sched;
    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;

    logic        clk = 1'b0, reset = 1'b0, start = 1'b0, ismu_d = 1'b0;
    logic [2:0]  multctrl = 3'd0;
    logic [1:0]  muwe = 2'd0, mure = 2'd0;
    logic [31:0] rs = 32'd0, rt = 32'd0;
    logic        busy, stall;
    logic [31:0] rdata, hi, lo;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, hi_pre, lo_pre, exp_hi, exp_lo;
        int          lat;
    } vec_t;
    typedef struct {
        logic [31:0] hi, lo;
    } res_t;

    res_t sb[$];
    vec_t vecs[10];
    int   errors = 0, checks = 0;

    mdu_sched dut (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_multctrl(multctrl),
        .i_muwe(muwe), .i_mure(mure), .i_rs_data(rs), .i_rt_data(rt),
        .i_ismu_d(ismu_d), .o_busy(busy), .o_stall(stall), .o_rdata(rdata),
        .o_hi(hi), .o_lo(lo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [31:0] h, input logic [31:0] l);
        muwe = 2'd1; rs = h; tick();
        muwe = 2'd2; rs = l; tick();
        muwe = 2'd0;
        chk("preload_hi", hi, h);
        chk("preload_lo", lo, l);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            tick();
        end
    endtask

    task automatic pop_check(input string tag);
        res_t r;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_scoreboard: got empty queue expected an entry", tag);
        end else begin
            r = sb.pop_front();
            chk({tag, "_hi"}, hi, r.hi);
            chk({tag, "_lo"}, lo, r.lo);
            mure = 2'd2; #1;
            chk({tag, "_mflo"}, rdata, r.lo);
            mure = 2'd1; #1;
            chk({tag, "_mfhi"}, rdata, r.hi);
            mure = 2'd0;
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int n;
        preload(v.hi_pre, v.lo_pre);
        ismu_d = 1'b1;
        start = 1'b1; multctrl = v.op; rs = v.a; rt = v.b;
        #1;
        chk({tag, "_start_stall"}, 32'(stall), 32'd1);
        sb.push_back('{hi: v.exp_hi, lo: v.exp_lo});
        tick();
        start = 1'b0; multctrl = 3'd0;
        wait_idle(n);
        chk({tag, "_busy_cycles"}, 32'(n), 32'(v.lat));
        pop_check(tag);
    endtask

    initial begin
        int n;
        vecs[0] = '{3'd1, 32'hFFFF_FFFE, 32'd3,         32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFA, MUL_LAT};
        vecs[1] = '{3'd3, 32'hFFFF_FFF9, 32'd2,         32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT};
        vecs[2] = '{3'd4, 32'hFFFF_FFF9, 32'd2,         32'h0, 32'h0, 32'h0000_0001, 32'h7FFF_FFFC, DIV_LAT};
        vecs[3] = '{3'd4, 32'h0000_0042, 32'd0,         32'h5678, 32'h1234, 32'h5678, 32'h1234, DIV_LAT};
        vecs[4] = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h9, 32'h9, 32'h0, 32'h8000_0000, DIV_LAT};
        vecs[5] = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'hFFFF_FFFE, 32'h0000_0001, MUL_LAT};
        vecs[6] = '{3'd1, 32'd7,         32'hFFFF_FFFD, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFEB, MUL_LAT};
        vecs[7] = '{3'd3, 32'd7,         32'hFFFF_FFFE, 32'h0, 32'h0, 32'h0000_0001, 32'hFFFF_FFFD, DIV_LAT};
        vecs[8] = '{3'd3, 32'd100,       32'd0,         32'hAAAA, 32'hBBBB, 32'hAAAA, 32'hBBBB, DIV_LAT};
        vecs[9] = '{3'd2, 32'h0001_0000, 32'h0001_0000, 32'h0, 32'h0, 32'h0000_0001, 32'h0000_0000, MUL_LAT};

        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_stall", 32'(stall), 32'd0);
        chk("reset_rdata", rdata, 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        preload(32'h0, 32'h0);
        ismu_d = 1'b0;
        start = 1'b1; multctrl = 3'd2; rs = 32'hFFFF_FFFF; rt = 32'hFFFF_FFFF;
        #1;
        chk("nonmdu_start_stall", 32'(stall), 32'd0);
        sb.push_back('{hi: 32'hFFFF_FFFE, lo: 32'h0000_0001});
        tick();
        start = 1'b0; multctrl = 3'd0;
        muwe = 2'd2; rs = 32'hAAAA;
        #1;
        chk("run_nonmdu_stall", 32'(stall), 32'd0);
        chk("run_busy", 32'(busy), 32'd1);
        tick();
        muwe = 2'd0; ismu_d = 1'b1;
        #1;
        chk("run_mdu_stall", 32'(stall), 32'd1);
        start = 1'b1; multctrl = 3'd3; rs = 32'd1; rt = 32'd1;
        tick();
        start = 1'b0; multctrl = 3'd0;
        wait_idle(n);
        chk("gate_busy_cycles", 32'(n + 2), 32'(MUL_LAT));
        pop_check("gate");

        ismu_d = 1'b1;
        start = 1'b1; multctrl = 3'd5; muwe = 2'd1; rs = 32'hDEAD_BEEF;
        #1;
        chk("bad_op_stall", 32'(stall), 32'd0);
        tick();
        chk("bad_op_busy", 32'(busy), 32'd0);
        chk("start_drops_muwe", hi, 32'hFFFF_FFFE);
        start = 1'b0; multctrl = 3'd0; muwe = 2'd0;

        preload(32'h11, 32'h22);
        start = 1'b1; multctrl = 3'd3; rs = 32'd100; rt = 32'd7;
        tick();
        start = 1'b0; multctrl = 3'd0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("async_reset_busy", 32'(busy), 32'd0);
        chk("async_reset_stall", 32'(stall), 32'd0);
        chk("async_reset_hi", hi, 32'd0);
        chk("async_reset_lo", lo, 32'd0);
        #1;
        reset = 1'b1;
        tick();
        run_vec('{3'd1, 32'd3, 32'd4, 32'h0, 32'h0, 32'h0, 32'd12, MUL_LAT}, "post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
